// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard scheduler.
// Stage control bundle, scheduler states and counter helpers.
package hazard_ctrl_pkg;

  localparam int unsigned REG_AW = 5;

  typedef struct packed {
    logic stall;
    logic squash;
  } stage_ctrl_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    REDIRECT = 2'd2
  } hazard_state_e;

  localparam stage_ctrl_t CTRL_RUN = '{stall: 1'b0, squash: 1'b0};
  localparam stage_ctrl_t CTRL_STL = '{stall: 1'b1, squash: 1'b0};
  localparam stage_ctrl_t CTRL_SQH = '{stall: 1'b0, squash: 1'b1};

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/hazard_ctrl_load_use_detect.sv
// Load-use detector: flags a decode source register produced by
// a load still sitting in execute.
module hazard_ctrl_load_use_detect
  import hazard_ctrl_pkg::*;
(
  input  logic              id_valid_i,
  input  logic              id_rs1_used_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic              id_rs2_used_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              ex_valid_i,
  input  logic              ex_mem_read_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  output logic              hazard_o
);

  logic ld_live;
  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    ld_live  = ex_valid_i & ex_mem_read_i
             & (ex_rd_i != '0) & id_valid_i;
    rs1_hit  = id_rs1_used_i & (id_rs1_i == ex_rd_i);
    rs2_hit  = id_rs2_used_i & (id_rs2_i == ex_rd_i);
    hazard_o = ld_live & (rs1_hit | rs2_hit);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Central 5-stage pipeline scheduler: mem wait, redirect, load-use.
// Optional perf counters when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT      = 64,
  parameter int unsigned REDIRECT_BUBBLES = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic              id_rs1_used_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic              id_rs2_used_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              ex_valid_i,
  input  logic              ex_mem_read_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              ex_redirect_i,
  input  logic              mem_valid_i,
  input  logic              mem_req_i,
  input  logic              dmem_rvalid_i,
  output stage_ctrl_t       fetch_ctrl_o,
  output stage_ctrl_t       decode_ctrl_o,
  output stage_ctrl_t       execute_ctrl_o,
  output stage_ctrl_t       memory_ctrl_o,
  output stage_ctrl_t       wb_ctrl_o,
  output logic              err_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cycles_o,
  output logic [31:0]       load_use_cnt_o,
  output logic [31:0]       redirect_cnt_o
`endif
);

  localparam int unsigned WCW =
    (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WCW-1:0] WC_LAST =
    WCW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
  localparam logic [2:0] RB_LOAD = 3'(REDIRECT_BUBBLES);

  hazard_state_e  state_q, state_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic [2:0]     bubble_cnt_q, bubble_cnt_d;

  logic lu_hazard;
  logic mem_wait;
  logic timeout;
  logic redir;
  logic lu_act;

  hazard_ctrl_load_use_detect u_lud (
    .id_valid_i    (id_valid_i),
    .id_rs1_used_i (id_rs1_used_i),
    .id_rs1_i      (id_rs1_i),
    .id_rs2_used_i (id_rs2_used_i),
    .id_rs2_i      (id_rs2_i),
    .ex_valid_i    (ex_valid_i),
    .ex_mem_read_i (ex_mem_read_i),
    .ex_rd_i       (ex_rd_i),
    .hazard_o      (lu_hazard)
  );

  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    bubble_cnt_d   = bubble_cnt_q;
    fetch_ctrl_o   = CTRL_RUN;
    decode_ctrl_o  = CTRL_RUN;
    execute_ctrl_o = CTRL_RUN;
    memory_ctrl_o  = CTRL_RUN;
    wb_ctrl_o      = CTRL_RUN;
    err_o          = 1'b0;

    // Inside MEM_WAIT only rvalid matters; elsewhere a new access may start a wait.
    if (state_q == MEM_WAIT) begin
      mem_wait = ~dmem_rvalid_i;
    end else begin
      mem_wait = mem_valid_i & mem_req_i & ~dmem_rvalid_i;
    end
    timeout = mem_wait & (MEM_TIMEOUT != 0)
            & (wait_cnt_q == WC_LAST);
    redir   = ex_valid_i & ex_redirect_i & ~mem_wait;
    lu_act  = lu_hazard & ~mem_wait & ~redir;

    unique case (1'b1)
      mem_wait: begin
        fetch_ctrl_o   = CTRL_STL;
        decode_ctrl_o  = CTRL_STL;
        execute_ctrl_o = CTRL_STL;
        wb_ctrl_o      = CTRL_SQH;
        bubble_cnt_d   = '0;
        if (timeout) begin
          memory_ctrl_o = CTRL_SQH;
          err_o         = 1'b1;
          state_d       = RUN;
          wait_cnt_d    = '0;
        end else begin
          memory_ctrl_o = CTRL_STL;
          state_d       = MEM_WAIT;
          if (!(&wait_cnt_q)) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end
      end
      redir: begin
        fetch_ctrl_o  = CTRL_SQH;
        decode_ctrl_o = CTRL_SQH;
        wait_cnt_d    = '0;
        if (REDIRECT_BUBBLES > 0) begin
          state_d      = REDIRECT;
          bubble_cnt_d = RB_LOAD;
        end else begin
          state_d      = RUN;
          bubble_cnt_d = '0;
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
        if (state_q == REDIRECT) begin
          fetch_ctrl_o = CTRL_SQH;
          if (bubble_cnt_q > 3'd1) begin
            state_d      = REDIRECT;
            bubble_cnt_d = bubble_cnt_q - 3'd1;
          end else begin
            bubble_cnt_d = '0;
          end
        end
        // Fetch output is already a bubble while draining a redirect.
        if (lu_act) begin
          if (state_q != REDIRECT) begin
            fetch_ctrl_o = CTRL_STL;
          end
          decode_ctrl_o  = CTRL_STL;
          execute_ctrl_o = CTRL_SQH;
        end
      end
    endcase

    if (rst_i) begin
      state_d        = RUN;
      wait_cnt_d     = '0;
      bubble_cnt_d   = '0;
      fetch_ctrl_o   = CTRL_SQH;
      decode_ctrl_o  = CTRL_SQH;
      execute_ctrl_o = CTRL_SQH;
      memory_ctrl_o  = CTRL_SQH;
      wb_ctrl_o      = CTRL_SQH;
      err_o          = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= RUN;
      wait_cnt_q   <= '0;
      bubble_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] load_use_cnt_q, load_use_cnt_d;
  logic [31:0] redirect_cnt_q, redirect_cnt_d;
  logic        any_stall;

  always_comb begin
    any_stall = fetch_ctrl_o.stall | decode_ctrl_o.stall
              | execute_ctrl_o.stall | memory_ctrl_o.stall
              | wb_ctrl_o.stall;
    stall_cycles_d = stall_cycles_q;
    load_use_cnt_d = load_use_cnt_q;
    redirect_cnt_d = redirect_cnt_q;
    if (any_stall) begin
      stall_cycles_d = sat_inc32(stall_cycles_q);
    end
    if (lu_act) begin
      load_use_cnt_d = sat_inc32(load_use_cnt_q);
    end
    if (redir) begin
      redirect_cnt_d = sat_inc32(redirect_cnt_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cycles_q <= '0;
      load_use_cnt_q <= '0;
      redirect_cnt_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      load_use_cnt_q <= load_use_cnt_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  assign stall_cycles_o = stall_cycles_q;
  assign load_use_cnt_o = load_use_cnt_q;
  assign redirect_cnt_o = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with MEM_TIMEOUT=4, REDIRECT_BUBBLES=2.
// Expected control words are checked per stage on sample.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       id_valid_i, id_rs1_used_i, id_rs2_used_i;
  logic [4:0] id_rs1_i, id_rs2_i, ex_rd_i;
  logic       ex_valid_i, ex_mem_read_i, ex_redirect_i;
  logic       mem_valid_i, mem_req_i, dmem_rvalid_i;
  stage_ctrl_t fetch_ctrl_o, decode_ctrl_o, execute_ctrl_o;
  stage_ctrl_t memory_ctrl_o, wb_ctrl_o;
  logic       err_o;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_o, load_use_cnt_o, redirect_cnt_o;
`endif

  localparam logic [1:0] N  = 2'b00;
  localparam logic [1:0] ST = 2'b10;
  localparam logic [1:0] SQ = 2'b01;

  int   n_eval = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .MEM_TIMEOUT      (4),
    .REDIRECT_BUBBLES (2)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .id_valid_i     (id_valid_i),
    .id_rs1_used_i  (id_rs1_used_i),
    .id_rs1_i       (id_rs1_i),
    .id_rs2_used_i  (id_rs2_used_i),
    .id_rs2_i       (id_rs2_i),
    .ex_valid_i     (ex_valid_i),
    .ex_mem_read_i  (ex_mem_read_i),
    .ex_rd_i        (ex_rd_i),
    .ex_redirect_i  (ex_redirect_i),
    .mem_valid_i    (mem_valid_i),
    .mem_req_i      (mem_req_i),
    .dmem_rvalid_i  (dmem_rvalid_i),
    .fetch_ctrl_o   (fetch_ctrl_o),
    .decode_ctrl_o  (decode_ctrl_o),
    .execute_ctrl_o (execute_ctrl_o),
    .memory_ctrl_o  (memory_ctrl_o),
    .wb_ctrl_o      (wb_ctrl_o),
    .err_o          (err_o)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles_o (stall_cycles_o),
    .load_use_cnt_o (load_use_cnt_o),
    .redirect_cnt_o (redirect_cnt_o)
`endif
  );

  task automatic clr();
    id_valid_i    = 1'b0;
    id_rs1_used_i = 1'b0;
    id_rs1_i      = 5'd0;
    id_rs2_used_i = 1'b0;
    id_rs2_i      = 5'd0;
    ex_valid_i    = 1'b0;
    ex_mem_read_i = 1'b0;
    ex_rd_i       = 5'd0;
    ex_redirect_i = 1'b0;
    mem_valid_i   = 1'b0;
    mem_req_i     = 1'b0;
    dmem_rvalid_i = 1'b0;
  endtask

  task automatic load_use(input logic [4:0] rd,
                          input logic [4:0] rs1,
                          input logic [4:0] rs2,
                          input logic       rs2_used);
    id_valid_i    = 1'b1;
    id_rs1_used_i = 1'b1;
    id_rs1_i      = rs1;
    id_rs2_used_i = rs2_used;
    id_rs2_i      = rs2;
    ex_valid_i    = 1'b1;
    ex_mem_read_i = 1'b1;
    ex_rd_i       = rd;
  endtask

  task automatic chk(input string tag,
                     input logic [1:0] f, input logic [1:0] d,
                     input logic [1:0] e, input logic [1:0] m,
                     input logic [1:0] w, input logic err);
    #2;
    n_eval++;
    if (fetch_ctrl_o !== f) begin
      n_fail++;
      $error("FAIL %s fetch=%b exp=%b", tag, fetch_ctrl_o, f);
    end
    if (decode_ctrl_o !== d) begin
      n_fail++;
      $error("FAIL %s decode=%b exp=%b", tag, decode_ctrl_o, d);
    end
    if (execute_ctrl_o !== e) begin
      n_fail++;
      $error("FAIL %s execute=%b exp=%b", tag, execute_ctrl_o, e);
    end
    if (memory_ctrl_o !== m) begin
      n_fail++;
      $error("FAIL %s memory=%b exp=%b", tag, memory_ctrl_o, m);
    end
    if (wb_ctrl_o !== w) begin
      n_fail++;
      $error("FAIL %s wb=%b exp=%b", tag, wb_ctrl_o, w);
    end
    if (err_o !== err) begin
      n_fail++;
      $error("FAIL %s err=%b exp=%b", tag, err_o, err);
    end
    @(negedge clk);
  endtask

  initial begin
    rst_i = 1'b1;
    clr();
    @(negedge clk);
    chk("rst_c0", SQ, SQ, SQ, SQ, SQ, 1'b0);
    chk("rst_c1", SQ, SQ, SQ, SQ, SQ, 1'b0);
    rst_i = 1'b0;
    chk("post_rst", N, N, N, N, N, 1'b0);

    load_use(5'd5, 5'd5, 5'd7, 1'b1);
    chk("lu_rs1", ST, ST, SQ, N, N, 1'b0);
    clr();
    chk("lu_after", N, N, N, N, N, 1'b0);
    load_use(5'd0, 5'd0, 5'd7, 1'b1);
    chk("lu_rd0", N, N, N, N, N, 1'b0);
    load_use(5'd9, 5'd6, 5'd9, 1'b1);
    chk("lu_rs2", ST, ST, SQ, N, N, 1'b0);
    load_use(5'd9, 5'd6, 5'd9, 1'b0);
    chk("lu_rs2_unused", N, N, N, N, N, 1'b0);
    clr();

    mem_valid_i = 1'b1;
    mem_req_i   = 1'b1;
    chk("mw_c1", ST, ST, ST, ST, SQ, 1'b0);
    chk("mw_c2", ST, ST, ST, ST, SQ, 1'b0);
    chk("mw_c3", ST, ST, ST, ST, SQ, 1'b0);
    dmem_rvalid_i = 1'b1;
    chk("mw_rvalid", N, N, N, N, N, 1'b0);
    clr();
    chk("mw_after", N, N, N, N, N, 1'b0);

    mem_valid_i   = 1'b1;
    mem_req_i     = 1'b1;
    dmem_rvalid_i = 1'b1;
    chk("mw_same_cyc", N, N, N, N, N, 1'b0);
    clr();
    chk("mw_same_after", N, N, N, N, N, 1'b0);

    mem_valid_i = 1'b1;
    mem_req_i   = 1'b1;
    chk("to_c1", ST, ST, ST, ST, SQ, 1'b0);
    chk("to_c2", ST, ST, ST, ST, SQ, 1'b0);
    chk("to_c3", ST, ST, ST, ST, SQ, 1'b0);
    chk("to_c4", ST, ST, ST, SQ, SQ, 1'b1);
    clr();
    chk("to_after", N, N, N, N, N, 1'b0);

    ex_valid_i    = 1'b1;
    ex_redirect_i = 1'b1;
    chk("rd_c0", SQ, SQ, N, N, N, 1'b0);
    clr();
    chk("rd_c1", SQ, N, N, N, N, 1'b0);
    chk("rd_c2", SQ, N, N, N, N, 1'b0);
    chk("rd_c3", N, N, N, N, N, 1'b0);

    load_use(5'd5, 5'd5, 5'd7, 1'b1);
    ex_redirect_i = 1'b1;
    chk("rd_lu_c0", SQ, SQ, N, N, N, 1'b0);
    clr();
    chk("rd_lu_c1", SQ, N, N, N, N, 1'b0);
    chk("rd_lu_c2", SQ, N, N, N, N, 1'b0);
    chk("rd_lu_c3", N, N, N, N, N, 1'b0);

    mem_valid_i   = 1'b1;
    mem_req_i     = 1'b1;
    ex_valid_i    = 1'b1;
    ex_redirect_i = 1'b1;
    chk("rdmw_c1", ST, ST, ST, ST, SQ, 1'b0);
    chk("rdmw_c2", ST, ST, ST, ST, SQ, 1'b0);
    dmem_rvalid_i = 1'b1;
    chk("rdmw_rvalid", SQ, SQ, N, N, N, 1'b0);
    clr();
    chk("rdmw_b1", SQ, N, N, N, N, 1'b0);
    chk("rdmw_b2", SQ, N, N, N, N, 1'b0);
    chk("rdmw_run", N, N, N, N, N, 1'b0);

    mem_valid_i = 1'b1;
    mem_req_i   = 1'b1;
    chk("rstmw_c1", ST, ST, ST, ST, SQ, 1'b0);
    chk("rstmw_c2", ST, ST, ST, ST, SQ, 1'b0);
    chk("rstmw_c3", ST, ST, ST, ST, SQ, 1'b0);
    rst_i = 1'b1;
    chk("rstmw_rst", SQ, SQ, SQ, SQ, SQ, 1'b0);
    rst_i = 1'b0;
    clr();
    chk("rstmw_run", N, N, N, N, N, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_eval, n_fail);
    $finish;
  end

endmodule
